// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB register-file completer:
// FSM state encoding, default widths, error decode and byte-strobe merge.
package apb_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_ADDR_WIDTH = 12;
   localparam int MAX_DATA_WIDTH     = 128;
   localparam int MAX_STRB_WIDTH     = MAX_DATA_WIDTH / 8;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } apb_state_e;

   // Flags a byte address that is not word aligned or whose word index is past the bank.
   function automatic logic addr_err(input logic [31:0] addr, input int unsigned num_regs);
      logic err;
      err = (addr[1:0] != 2'b00) || ((addr >> 2) >= num_regs);
      return err;
   endfunction

   function automatic logic [MAX_DATA_WIDTH-1:0] strb_merge(
      input logic [MAX_DATA_WIDTH-1:0] old_data,
      input logic [MAX_DATA_WIDTH-1:0] new_data,
      input logic [MAX_STRB_WIDTH-1:0] strb
   );
      logic [MAX_DATA_WIDTH-1:0] merged;
      merged = old_data;
      for (int b = 0; b < MAX_STRB_WIDTH; b++) begin
         if (strb[b]) begin
            merged[8*b +: 8] = new_data[8*b +: 8];
         end else begin
            merged[8*b +: 8] = old_data[8*b +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/apb_regfile.sv
// Register bank: NUM_REGS words with byte-strobed writes and a combinational read port.
// Out-of-range indices never write and read back as zero.
module apb_regfile
   import apb_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int NUM_REGS   = 16,
   parameter int IDX_WIDTH  = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [IDX_WIDTH-1:0]    wr_idx,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_strb,
   input  logic [IDX_WIDTH-1:0]    rd_idx,
   output logic [DATA_WIDTH-1:0]   rd_data
);

   localparam int REG_IDX_WIDTH = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

   always_comb begin
      regs_d = regs_q;
      if (wr_en && (wr_idx < IDX_WIDTH'(NUM_REGS))) begin
         regs_d[wr_idx[REG_IDX_WIDTH-1:0]] = DATA_WIDTH'(strb_merge(
            MAX_DATA_WIDTH'(regs_q[wr_idx[REG_IDX_WIDTH-1:0]]),
            MAX_DATA_WIDTH'(wr_data),
            MAX_STRB_WIDTH'(wr_strb)));
      end else begin
         regs_d = regs_q;
      end
   end

   always_comb begin
      rd_data = '0;
      if (rd_idx < IDX_WIDTH'(NUM_REGS)) begin
         rd_data = regs_q[rd_idx[REG_IDX_WIDTH-1:0]];
      end else begin
         rd_data = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB4-subset completer in front of apb_regfile: setup/access FSM, programmable
// wait states, and registered PREADY/PRDATA/PSLVERR.
module apb_regfile_slave
   import apb_pkg::*;
#(
   parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
   parameter int NUM_REGS    = 16,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    psel,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [ADDR_WIDTH-1:0]   paddr,
   input  logic [DATA_WIDTH-1:0]   pwdata,
   input  logic [DATA_WIDTH/8-1:0] pstrb,
   output logic                    pready,
   output logic [DATA_WIDTH-1:0]   prdata,
   output logic                    pslverr
);

   localparam int IDX_WIDTH = ADDR_WIDTH - 2;
   localparam int CNT_W     = 4;

   apb_state_e              state_q,   state_d;
   logic [CNT_W-1:0]        cnt_q,     cnt_d;
   logic                    pwrite_q,  pwrite_d;
   logic [ADDR_WIDTH-1:0]   paddr_q,   paddr_d;
   logic [DATA_WIDTH-1:0]   pwdata_q,  pwdata_d;
   logic [DATA_WIDTH/8-1:0] pstrb_q,   pstrb_d;
   logic                    pready_q,  pready_d;
   logic [DATA_WIDTH-1:0]   prdata_q,  prdata_d;
   logic                    pslverr_q, pslverr_d;

   logic                    wr_en_s;
   logic [IDX_WIDTH-1:0]    rd_idx_s;
   logic [DATA_WIDTH-1:0]   rd_data_s;
   logic                    rsp_err_s;
   logic                    rsp_write_s;

   apb_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .IDX_WIDTH  (IDX_WIDTH)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en_s),
      .wr_idx  (paddr_q[ADDR_WIDTH-1:2]),
      .wr_data (pwdata_q),
      .wr_strb (pstrb_q),
      .rd_idx  (rd_idx_s),
      .rd_data (rd_data_s)
   );

   // With zero wait states the response is built from the live setup-phase address.
   always_comb begin
      rd_idx_s = paddr_q[ADDR_WIDTH-1:2];
      if (state_q == IDLE) begin
         rd_idx_s = paddr[ADDR_WIDTH-1:2];
      end else begin
         rd_idx_s = paddr_q[ADDR_WIDTH-1:2];
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      pstrb_d     = pstrb_q;
      pready_d    = 1'b0;
      prdata_d    = '0;
      pslverr_d   = 1'b0;
      wr_en_s     = 1'b0;
      rsp_err_s   = addr_err(32'(paddr_q), NUM_REGS);
      rsp_write_s = pwrite_q;
      case (state_q)
         IDLE: begin
            if (psel && !penable) begin
               state_d     = ACCESS;
               pwrite_d    = pwrite;
               paddr_d     = paddr;
               pwdata_d    = pwdata;
               pstrb_d     = pstrb;
               cnt_d       = CNT_W'(WAIT_CYCLES);
               rsp_err_s   = addr_err(32'(paddr), NUM_REGS);
               rsp_write_s = pwrite;
               pready_d    = (WAIT_CYCLES == 0);
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            // The response cycle is the commit point; an abort before it leaves the bank untouched.
            if (pready_q) begin
               state_d = IDLE;
               wr_en_s = pwrite_q && !pslverr_q;
            end else if (!psel) begin
               state_d = IDLE;
            end else if (penable && (cnt_q != CNT_W'(0))) begin
               cnt_d    = cnt_q - CNT_W'(1);
               pready_d = (cnt_q == CNT_W'(1));
            end else begin
               cnt_d = cnt_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (pready_d) begin
         pslverr_d = rsp_err_s;
         prdata_d  = (rsp_err_s || rsp_write_s) ? '0 : rd_data_s;
      end else begin
         pslverr_d = 1'b0;
         prdata_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pstrb_q   <= '0;
         pready_q  <= 1'b0;
         prdata_q  <= '0;
         pslverr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pstrb_q   <= pstrb_d;
         pready_q  <= pready_d;
         prdata_q  <= prdata_d;
         pslverr_q <= pslverr_d;
      end
   end

   assign pready  = pready_q;
   assign prdata  = prdata_q;
   assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Bench for apb_regfile_slave: one instance with one wait state, one with none,
// directed scenarios plus random traffic checked against an array model.
module tb_apb_regfile_slave;

   localparam int DW = 32;
   localparam int AW = 12;
   localparam int NR = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          psel0, psel1, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic [3:0]    pstrb;
   logic          pready0, pready1, pslverr0, pslverr1;
   logic [DW-1:0] prdata0, prdata1;

   int n_checks = 0;
   int n_pass   = 0;
   logic [DW-1:0] mem [2][NR];

   always #5 clk = ~clk;

   apb_regfile_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .WAIT_CYCLES(1)) dut_w1 (
      .clk(clk), .rst(rst), .psel(psel0), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
      .pready(pready0), .prdata(prdata0), .pslverr(pslverr0)
   );

   apb_regfile_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .WAIT_CYCLES(0)) dut_w0 (
      .clk(clk), .rst(rst), .psel(psel1), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
      .pready(pready1), .prdata(prdata1), .pslverr(pslverr1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic rdy(input int s);
      return (s == 0) ? pready0 : pready1;
   endfunction

   function automatic logic [31:0] rdat(input int s);
      return (s == 0) ? prdata0 : prdata1;
   endfunction

   function automatic logic serr(input int s);
      return (s == 0) ? pslverr0 : pslverr1;
   endfunction

   function automatic bit addr_bad(input logic [AW-1:0] a);
      return ((int'(a) % 4) != 0) || ((int'(a) / 4) >= NR);
   endfunction

   // One complete transfer; the next call may start its setup in the very next cycle.
   task automatic xfer(input int s, input bit wr, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [3:0] st, input string tag);
      int          lat;
      int          wt;
      int          idx;
      bit          exp_e;
      logic [31:0] exp_rd;
      wt     = (s == 0) ? 1 : 0;
      exp_e  = addr_bad(a);
      idx    = int'(a) / 4;
      exp_rd = 32'h0;
      if (!exp_e) exp_rd = mem[s][idx];
      @(negedge clk);
      check({tag, "/pre_prdata"}, rdat(s), 32'h0);
      pwrite  = wr;
      paddr   = a;
      pwdata  = d;
      pstrb   = st;
      penable = 1'b0;
      psel0   = (s == 0);
      psel1   = (s == 1);
      @(negedge clk);
      penable = 1'b1;
      lat     = 1;
      while (!rdy(s) && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "/ready_cycle"}, 32'(lat), 32'(1 + wt));
      check({tag, "/pslverr"}, 32'(serr(s)), 32'(exp_e));
      if (!wr) check({tag, "/prdata"}, rdat(s), exp_rd);
      if (wr && !exp_e) begin
         for (int b = 0; b < 4; b++) begin
            if (st[b]) mem[s][idx][8*b +: 8] = d[8*b +: 8];
         end
      end
   endtask

   task automatic go_idle(input string tag);
      @(negedge clk);
      check({tag, "/ready_one_cycle"}, 32'(pready0 | pready1), 32'h0);
      psel0   = 1'b0;
      psel1   = 1'b0;
      penable = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          s;
      int          r;
      bit          wr;
      logic [AW-1:0] a;
      rst = 1'b1; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0;
      for (int d = 0; d < 2; d++) for (int i = 0; i < NR; i++) mem[d][i] = 32'h0;
      repeat (3) @(negedge clk);
      check("reset/pready",  32'({pready0, pready1}), 32'h0);
      check("reset/pslverr", 32'({pslverr0, pslverr1}), 32'h0);
      check("reset/prdata",  prdata0 | prdata1, 32'h0);
      rst = 1'b0;

      xfer(0, 1'b1, 12'h004, 32'h0000_0004, 4'hF, "basic_w");
      xfer(0, 1'b0, 12'h004, 32'h0, 4'h0, "basic_r");
      go_idle("basic");

      xfer(0, 1'b1, 12'h008, 32'hFFFF_FFFF, 4'hF, "strb_w1");
      xfer(0, 1'b1, 12'h008, 32'h0000_00AA, 4'b0001, "strb_w2");
      xfer(0, 1'b0, 12'h008, 32'h0, 4'h0, "strb_r");
      go_idle("strb");

      xfer(0, 1'b1, 12'hFFC, 32'hDEAD_BEEF, 4'hF, "err_range");
      xfer(0, 1'b1, 12'h006, 32'hCAFE_F00D, 4'hF, "err_align");
      xfer(0, 1'b0, 12'h000, 32'h0, 4'h0, "err_after_r");
      go_idle("err");

      for (int i = 0; i < 4; i++) xfer(0, 1'b1, AW'(4 * i), 32'(4 * i), 4'hF, "b2b_w");
      for (int i = 0; i < 4; i++) xfer(0, 1'b0, AW'(4 * i), 32'h0, 4'h0, "b2b_r");
      go_idle("b2b");

      // Abort: psel drops in the first access cycle
      @(negedge clk);
      pwrite = 1'b1; paddr = 12'h010; pwdata = 32'h0000_1234; pstrb = 4'hF;
      psel0 = 1'b1; penable = 1'b0;
      @(negedge clk);
      psel0 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort/no_ready", 32'(pready0), 32'h0);
      end
      xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, "abort_r");
      go_idle("abort");

      // Reset during the access phase of a write
      @(negedge clk);
      pwrite = 1'b1; paddr = 12'h00C; pwdata = 32'h5555_AAAA; pstrb = 4'hF;
      psel0 = 1'b1; penable = 1'b0;
      @(negedge clk);
      penable = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid/pready",  32'(pready0), 32'h0);
      check("rst_mid/pslverr", 32'(pslverr0), 32'h0);
      check("rst_mid/prdata",  prdata0, 32'h0);
      rst = 1'b0; psel0 = 1'b0; penable = 1'b0;
      for (int d = 0; d < 2; d++) for (int i = 0; i < NR; i++) mem[d][i] = 32'h0;
      xfer(0, 1'b0, 12'h00C, 32'h0, 4'h0, "rst_mid_r");
      go_idle("rst_mid");

      xfer(1, 1'b1, 12'h004, 32'h0000_0004, 4'hF, "w0_basic_w");
      xfer(1, 1'b0, 12'h004, 32'h0, 4'h0, "w0_basic_r");
      go_idle("w0_basic");

      for (int n = 0; n < 120; n++) begin
         s  = int'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         r  = int'($urandom_range(0, 9));
         if (r < 7)       a = AW'(4 * $urandom_range(0, NR - 1));
         else if (r == 7) a = AW'(4 * $urandom_range(0, NR - 1) + $urandom_range(1, 3));
         else             a = AW'($urandom);
         xfer(s, wr, a, $urandom, 4'($urandom), "rand");
         if ($urandom_range(0, 2) == 0) go_idle("rand");
      end
      go_idle("final");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
